// File: rtl/key_event_encoder.sv
// Debounces the 20-bit key matrix vector, turns stable changes into press/release
// event codes, and queues them in a small FIFO behind a valid/ready handshake.
module key_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPORT_RELEASE  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [19:0]                   key_state,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [5:0]                    ev_data,
    output logic [19:0]                   key_down,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    function automatic logic [4:0] lowest_idx(input logic [19:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 19; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    logic [19:0]      r_raw;
    logic [19:0]      r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [19:0]      r_key_down;
    logic [19:0]      r_pend_press;
    logic [19:0]      r_pend_rel;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_mem [FIFO_DEPTH];
    logic [5:0]       r_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic             w_restart;
    logic             w_kd_upd;
    logic [19:0]      w_set_press;
    logic [19:0]      w_set_rel;
    logic             w_use_press;
    logic [19:0]      w_sel_vec;
    logic [4:0]       w_sel_idx;
    logic [19:0]      w_sel_onehot;
    logic [5:0]       w_ev;
    logic             w_we;
    logic [19:0]      w_clr_press;
    logic [19:0]      w_clr_rel;
    logic [19:0]      w_remaining;
    logic             w_full;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;
    logic [PTR_W-1:0] w_rd_ptr_inc;

    // Stages 1-2: input capture and whole-vector debounce
    assign w_restart = (r_raw != r_cand);
    assign w_kd_upd  = !w_restart && (r_cnt == CNT_MAX) && (r_cand != r_key_down);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_raw      <= '0;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_key_down <= '0;
        end else begin
            r_raw <= key_state;
            if (w_restart) begin
                r_cand <= r_raw;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_kd_upd) r_key_down <= r_cand;
        end
    end

    // Stage 3: pending masks, emitter clears land before new edge bits are ORed in
    assign w_set_press = w_kd_upd ? (r_cand & ~r_key_down) : '0;
    assign w_set_rel   = (w_kd_upd && (REPORT_RELEASE != 0)) ? (r_key_down & ~r_cand) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_press <= '0;
            r_pend_rel   <= '0;
        end else begin
            r_pend_press <= (r_pend_press & ~w_clr_press) | w_set_press;
            r_pend_rel   <= (r_pend_rel & ~w_clr_rel) | w_set_rel;
        end
    end

    // Stage 4: emitter FSM, presses drain before releases, lowest index first
    assign w_use_press  = |r_pend_press;
    assign w_sel_vec    = w_use_press ? r_pend_press : r_pend_rel;
    assign w_sel_idx    = lowest_idx(w_sel_vec);
    assign w_sel_onehot = 20'd1 << w_sel_idx;
    assign w_ev         = {w_use_press, w_sel_idx};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_we        = (r_state == S_EMIT) && !w_full;
        w_clr_press = '0;
        w_clr_rel   = '0;
        if (w_we) begin
            if (w_use_press) w_clr_press = w_sel_onehot;
            else             w_clr_rel   = w_sel_onehot;
        end
    end

    assign w_remaining = (r_pend_press & ~w_clr_press) | (r_pend_rel & ~w_clr_rel);

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_remaining != '0) begin
            w_state_nxt = (w_level_nxt == LVL_FULL) ? S_STALL : S_EMIT;
        end
    end

    // FIFO: registered head copy so ev_data comes straight from a flop
    assign w_full       = (r_level == LVL_FULL);
    assign ev_valid     = (r_level != '0);
    assign w_pop        = ev_valid && ev_ready;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
    assign w_level_nxt  = r_level + {{(LVL_W-1){1'b0}}, w_we} - {{(LVL_W-1){1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= w_ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
            if (w_we && ((r_level == '0) || ((r_level == LVL_W'(1)) && w_pop))) begin
                r_head <= w_ev;
            end else if (w_pop && (r_level > LVL_W'(1))) begin
                r_head <= r_mem[w_rd_ptr_inc];
            end
        end
    end

    assign ev_data    = r_head;
    assign key_down   = r_key_down;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: reset, debounce, event ordering,
// backpressure and release reporting with and without REPORT_RELEASE.
module tb_key_event_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] key_state;
    logic        ev_ready;
    logic        ev_valid,    ev_valid_nr;
    logic [5:0]  ev_data,     ev_data_nr;
    logic [19:0] key_down,    key_down_nr;
    logic [2:0]  fifo_level,  fifo_level_nr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [5:0] q_ev[$];
    int         q_cyc[$];
    logic [5:0] q_nr[$];

    always #5 clk = ~clk;

    key_event_encoder #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .REPORT_RELEASE(1)) dut (
        .clk(clk), .rst(rst), .key_state(key_state), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_data(ev_data), .key_down(key_down), .fifo_level(fifo_level)
    );

    key_event_encoder #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .REPORT_RELEASE(0)) dut_nr (
        .clk(clk), .rst(rst), .key_state(key_state), .ev_valid(ev_valid_nr),
        .ev_ready(ev_ready), .ev_data(ev_data_nr), .key_down(key_down_nr), .fifo_level(fifo_level_nr)
    );

    task automatic reset_all();
        rst = 1'b0; key_state = '0; ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Samples at the current negedge, then advances; cycle index i counts from the call.
    task automatic collect(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (ev_valid) begin q_ev.push_back(ev_data); q_cyc.push_back(i); end
            if (ev_valid_nr) q_nr.push_back(ev_data_nr);
            @(negedge clk);
        end
    endtask

    task automatic clear_queues();
        q_ev.delete(); q_cyc.delete(); q_nr.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; key_state = 20'h00021; ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        n_cmp++; if (key_down !== 20'h0) begin n_fail++; $display("FAIL rst_keydown: got %h want 0", key_down); end
        n_cmp++; if (ev_data !== 6'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", ev_data); end
        rst = 1'b1;
        repeat (22) @(negedge clk);
        n_cmp++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL rst_queued_level: got %0d want 2", fifo_level); end
        n_cmp++; if (ev_data !== 6'h20) begin n_fail++; $display("FAIL rst_queued_head: got %h want 20", ev_data); end
        n_cmp++; if (key_down !== 20'h00021) begin n_fail++; $display("FAIL rst_queued_keydown: got %h want 00021", key_down); end
        key_state = '0; rst = 1'b0;
        #1;
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", ev_valid); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
        n_cmp++; if (key_down !== 20'h0) begin n_fail++; $display("FAIL midrst_keydown: got %h want 0", key_down); end
        @(negedge clk);
        rst = 1'b1; ev_ready = 1'b1;
        clear_queues();
        collect(40);
        ev_ready = 1'b0;
        n_cmp++; if (q_ev.size() != 0) begin n_fail++; $display("FAIL midrst_stale_events: got %0d want 0", q_ev.size()); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_after_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_single_press();
        reset_all();
        key_state = 20'h00020;
        repeat (17) @(negedge clk);
        n_cmp++; if (key_down !== 20'h0) begin n_fail++; $display("FAIL press_kd_early: got %h want 0", key_down); end
        @(negedge clk);
        n_cmp++; if (key_down !== 20'h00020) begin n_fail++; $display("FAIL press_kd_t17: got %h want 00020", key_down); end
        @(negedge clk);
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL press_valid_early: got %b want 0", ev_valid); end
        @(negedge clk);
        n_cmp++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid_t19: got %b want 1", ev_valid); end
        n_cmp++; if (ev_data !== 6'h25) begin n_fail++; $display("FAIL press_data: got %h want 25", ev_data); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL press_level: got %0d want 1", fifo_level); end
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL press_pop_level: got %0d want 0", fifo_level); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL press_pop_valid: got %b want 0", ev_valid); end
    endtask

    task automatic test_glitch();
        reset_all();
        key_state = 20'h00008;
        repeat (10) @(negedge clk);
        key_state = '0;
        repeat (30) @(negedge clk);
        n_cmp++; if (key_down !== 20'h0) begin n_fail++; $display("FAIL glitch_keydown: got %h want 0", key_down); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", ev_valid); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL glitch_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp_ev [3];
        exp_ev = '{6'h20, 6'h27, 6'h33};
        reset_all();
        ev_ready = 1'b1;
        key_state = 20'h80081;
        clear_queues();
        collect(30);
        ev_ready = 1'b0;
        n_cmp++; if (q_ev.size() != 3) begin n_fail++; $display("FAIL simul_count: got %0d want 3", q_ev.size()); end
        if (q_ev.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (q_ev[k] !== exp_ev[k]) begin n_fail++; $display("FAIL simul_data%0d: got %h want %h", k, q_ev[k], exp_ev[k]); end
            end
            n_cmp++; if (q_cyc[0] != 20) begin n_fail++; $display("FAIL simul_first_cycle: got %0d want 20", q_cyc[0]); end
            n_cmp++; if (q_cyc[2] != q_cyc[0] + 2) begin n_fail++; $display("FAIL simul_consecutive: got %0d want %0d", q_cyc[2], q_cyc[0] + 2); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_ev [6];
        exp_ev = '{6'h21, 6'h22, 6'h24, 6'h28, 6'h2C, 6'h30};
        reset_all();
        ev_ready = 1'b0;
        key_state = 20'h11116;
        repeat (25) @(negedge clk);
        n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
        n_cmp++; if (dut.r_state !== 2'd2) begin n_fail++; $display("FAIL bp_stall_state: got %0d want 2", dut.r_state); end
        n_cmp++; if (ev_data !== 6'h21) begin n_fail++; $display("FAIL bp_head_hold: got %h want 21", ev_data); end
        clear_queues();
        ev_ready = 1'b1;
        collect(15);
        ev_ready = 1'b0;
        n_cmp++; if (q_ev.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", q_ev.size()); end
        if (q_ev.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++; if (q_ev[k] !== exp_ev[k]) begin n_fail++; $display("FAIL bp_data%0d: got %h want %h", k, q_ev[k], exp_ev[k]); end
            end
        end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", fifo_level); end
    endtask

    task automatic test_release();
        reset_all();
        ev_ready = 1'b1;
        key_state = 20'h00080;
        clear_queues();
        collect(25);
        key_state = '0;
        collect(25);
        ev_ready = 1'b0;
        n_cmp++; if (q_ev.size() != 2) begin n_fail++; $display("FAIL rel_count: got %0d want 2", q_ev.size()); end
        if (q_ev.size() == 2) begin
            n_cmp++; if (q_ev[0] !== 6'h27) begin n_fail++; $display("FAIL rel_press: got %h want 27", q_ev[0]); end
            n_cmp++; if (q_ev[1] !== 6'h07) begin n_fail++; $display("FAIL rel_release: got %h want 07", q_ev[1]); end
        end
        n_cmp++; if (q_nr.size() != 1) begin n_fail++; $display("FAIL norel_count: got %0d want 1", q_nr.size()); end
        if (q_nr.size() == 1) begin
            n_cmp++; if (q_nr[0] !== 6'h27) begin n_fail++; $display("FAIL norel_press: got %h want 27", q_nr[0]); end
        end
        n_cmp++; if (key_down_nr !== 20'h0) begin n_fail++; $display("FAIL norel_keydown: got %h want 0", key_down_nr); end
        n_cmp++; if (fifo_level_nr !== 3'd0) begin n_fail++; $display("FAIL norel_level: got %0d want 0", fifo_level_nr); end
    endtask

    initial begin
        rst = 1'b0; key_state = '0; ev_ready = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_back_to_back();
        test_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
